// File: rtl/ccr_branch_unit_if.sv
// Bus bundle between the execute stage and the CCR/branch unit.
// master: execute-stage side (drives flags and control, consumes CCR state).
// slave:  ccr_branch_unit.
interface ccr_branch_unit_if;
    logic       en;
    logic [3:0] alu_flags;
    logic [3:0] flag_we;
    logic       br_valid;
    logic [1:0] br_cond;
    logic       int_save;
    logic       int_restore;
    logic [3:0] flags_out;
    logic       br_taken;
    logic       stk_full;
    logic       stk_empty;
    logic       stk_err;

    modport master (
        output en, alu_flags, flag_we, br_valid, br_cond, int_save, int_restore,
        input  flags_out, br_taken, stk_full, stk_empty, stk_err
    );

    modport slave (
        input  en, alu_flags, flag_we, br_valid, br_cond, int_save, int_restore,
        output flags_out, br_taken, stk_full, stk_empty, stk_err
    );
endinterface

// File: rtl/ccr_branch_unit.sv
// Condition-code register {V,C,N,Z} with conditional-jump evaluation and a
// LIFO shadow stack for interrupt entry/return.
// Optional macro CCR_BYPASS_EN: the tested flag is forwarded from alu_flags when
// the same cycle writes it; otherwise br_taken only looks at the committed CCR.
module ccr_branch_unit #(
    parameter int unsigned SHADOW_DEPTH = 2
) (
    input logic               clk,
    input logic               reset,
    ccr_branch_unit_if.slave  bus
);
    localparam int unsigned CntW = $clog2(SHADOW_DEPTH + 1);

    logic [3:0]      ccr_q, ccr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [3:0]      stk_q [SHADOW_DEPTH];

    logic       sel;
    logic       taken;
    logic [3:0] upd;
    logic [3:0] top;
    logic       full;
    logic       empty;
    logic       push_en;

    assign full  = (cnt_q == CntW'(SHADOW_DEPTH));
    assign empty = (cnt_q == '0);

    // Tested flag, optionally forwarded from the flag result being written now.
    always_comb begin
`ifdef CCR_BYPASS_EN
        sel = bus.flag_we[bus.br_cond] ? bus.alu_flags[bus.br_cond] : ccr_q[bus.br_cond];
`else
        sel = ccr_q[bus.br_cond];
`endif
    end

    assign taken = bus.br_valid & sel;

    // Masked flag write, then clear of the flag a taken jump consumed.
    always_comb begin
        upd = (ccr_q & ~bus.flag_we) | (bus.alu_flags & bus.flag_we);
        if (taken) begin
            upd[bus.br_cond] = 1'b0;
        end
    end

    // Top-of-stack entry (entry cnt_q-1); zero when empty.
    always_comb begin
        top = '0;
        for (int i = 0; i < SHADOW_DEPTH; i++) begin
            if (cnt_q == CntW'(i + 1)) begin
                top = stk_q[i];
            end
        end
    end

    // Next-state: restore beats save; a stall holds everything.
    always_comb begin
        ccr_d   = ccr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        push_en = 1'b0;
        if (bus.en) begin
            if (bus.int_restore) begin
                if (!empty) begin
                    ccr_d = top;
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    err_d = 1'b1;
                end
                if (bus.int_save) begin
                    err_d = 1'b1;
                end
            end else begin
                ccr_d = upd;
                if (bus.int_save) begin
                    if (full) begin
                        err_d = 1'b1;
                    end else begin
                        push_en = 1'b1;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
        end
    end

    // State registers; the push stores the pre-update CCR.
    always_ff @(posedge clk) begin
        if (reset) begin
            ccr_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
            for (int i = 0; i < SHADOW_DEPTH; i++) begin
                stk_q[i] <= '0;
            end
        end else begin
            ccr_q <= ccr_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
            for (int i = 0; i < SHADOW_DEPTH; i++) begin
                if (push_en && cnt_q == CntW'(i)) begin
                    stk_q[i] <= ccr_q;
                end
            end
        end
    end

    assign bus.flags_out = ccr_q;
    assign bus.br_taken  = taken;
    assign bus.stk_full  = full;
    assign bus.stk_empty = empty;
    assign bus.stk_err   = err_q;
endmodule

// File: tb/tb_ccr_branch_unit.sv
// Directed bench for ccr_branch_unit (SHADOW_DEPTH=2); honours CCR_BYPASS_EN.
module tb_ccr_branch_unit;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    ccr_branch_unit_if bus ();

    ccr_branch_unit #(
        .SHADOW_DEPTH (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.en          = 1'b1;
        bus.alu_flags   = 4'b0000;
        bus.flag_we     = 4'b0000;
        bus.br_valid    = 1'b0;
        bus.br_cond     = 2'd0;
        bus.int_save    = 1'b0;
        bus.int_restore = 1'b0;
    endtask

    // Advance one edge, return 1 time unit after it with inputs back to idle.
    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic wr(input logic [3:0] we, input logic [3:0] val);
        bus.flag_we   = we;
        bus.alu_flags = val;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        idle();
        reset = 1'b1;
        wr(4'hF, 4'hF);
        @(posedge clk);
        #1;
        step();
        reset = 1'b0;

        // 1: reset state despite full-mask write held during reset
        check("rst_flags", bus.flags_out, 4'b0000);
        check("rst_empty", 4'(bus.stk_empty), 4'd1);
        check("rst_full",  4'(bus.stk_full),  4'd0);
        check("rst_err",   4'(bus.stk_err),   4'd0);

        // 2: partial mask, then stall holds state even with save requested
        wr(4'b0011, 4'b1010);
        step();
        check("mask_wr", bus.flags_out, 4'b0010);
        bus.en = 1'b0;
        wr(4'hF, 4'hF);
        bus.int_save = 1'b1;
        step();
        check("stall_hold",  bus.flags_out, 4'b0010);
        check("stall_nopush", 4'(bus.stk_empty), 4'd1);

        // 3: taken jump clears tested flag
        wr(4'hF, 4'b0001);
        step();
        bus.br_valid = 1'b1;
        bus.br_cond  = 2'd0;
        #1;
        check("jz_taken", 4'(bus.br_taken), 4'd1);
        step();
        check("jz_clear", bus.flags_out, 4'b0000);
        wr(4'b0001, 4'b0001);
        step();
        bus.br_valid = 1'b1;
        bus.br_cond  = 2'd0;
        wr(4'b0001, 4'b0001);
        #1;
        check("jz_taken_wr", 4'(bus.br_taken), 4'd1);
        step();
        check("clear_beats_wr", bus.flags_out, 4'b0000);
        wr(4'b0001, 4'b0001);
        step();
        bus.br_cond = 2'd0;
        #1;
        check("nobr_valid", 4'(bus.br_taken), 4'd0);
        bus.en       = 1'b0;
        bus.br_valid = 1'b1;
        #1;
        check("taken_stalled", 4'(bus.br_taken), 4'd1);
        step();
        check("stall_no_clear", bus.flags_out, 4'b0001);

        // 4: save/restore round trip, then underflow
        wr(4'hF, 4'b0110);
        step();
        bus.int_save = 1'b1;
        step();
        check("save_nonempty", 4'(bus.stk_empty), 4'd0);
        wr(4'hF, 4'b1001);
        step();
        check("post_save_wr", bus.flags_out, 4'b1001);
        bus.int_restore = 1'b1;
        wr(4'hF, 4'hF);
        bus.br_valid = 1'b1;
        bus.br_cond  = 2'd3;
        step();
        check("restore_val",   bus.flags_out, 4'b0110);
        check("restore_empty", 4'(bus.stk_empty), 4'd1);
        check("restore_noerr", 4'(bus.stk_err), 4'd0);
        bus.int_restore = 1'b1;
        step();
        check("underflow_hold", bus.flags_out, 4'b0110);
        check("underflow_err",  4'(bus.stk_err), 4'd1);

        // reset during a restore clears the error
        reset = 1'b1;
        bus.int_restore = 1'b1;
        step();
        reset = 1'b0;
        check("rst2_err",   4'(bus.stk_err), 4'd0);
        check("rst2_flags", bus.flags_out, 4'b0000);

        // 5: overflow at depth 2; pushes store the pre-update CCR
        wr(4'hF, 4'b0011);
        step();
        bus.int_save = 1'b1;
        wr(4'hF, 4'b0101);
        step();
        check("push1_full",  4'(bus.stk_full), 4'd0);
        check("push1_flags", bus.flags_out, 4'b0101);
        bus.int_save = 1'b1;
        wr(4'hF, 4'b1000);
        step();
        check("push2_full", 4'(bus.stk_full), 4'd1);
        check("push2_err",  4'(bus.stk_err), 4'd0);
        bus.int_save = 1'b1;
        wr(4'hF, 4'b1111);
        step();
        check("ovf_err",   4'(bus.stk_err), 4'd1);
        check("ovf_full",  4'(bus.stk_full), 4'd1);
        check("ovf_flags", bus.flags_out, 4'b1111);
        bus.int_restore = 1'b1;
        step();
        check("pop1_val",  bus.flags_out, 4'b0101);
        check("pop1_full", 4'(bus.stk_full), 4'd0);
        bus.int_restore = 1'b1;
        step();
        check("pop2_val",   bus.flags_out, 4'b0011);
        check("pop2_empty", 4'(bus.stk_empty), 4'd1);
        check("err_sticky", 4'(bus.stk_err), 4'd1);

        // save+restore together: restore wins, error raised
        reset = 1'b1;
        step();
        reset = 1'b0;
        wr(4'hF, 4'b0100);
        step();
        bus.int_save = 1'b1;
        wr(4'hF, 4'b0010);
        step();
        bus.int_save    = 1'b1;
        bus.int_restore = 1'b1;
        step();
        check("both_val",   bus.flags_out, 4'b0100);
        check("both_empty", 4'(bus.stk_empty), 4'd1);
        check("both_err",   4'(bus.stk_err), 4'd1);

        // 6: bypass of the tested flag
        reset = 1'b1;
        step();
        reset = 1'b0;
        wr(4'b0100, 4'b0100);
        bus.br_valid = 1'b1;
        bus.br_cond  = 2'd2;
        #1;
`ifdef CCR_BYPASS_EN
        check("byp_taken", 4'(bus.br_taken), 4'd1);
        step();
        check("byp_flags", bus.flags_out, 4'b0000);
`else
        check("byp_taken", 4'(bus.br_taken), 4'd0);
        step();
        check("byp_flags", bus.flags_out, 4'b0100);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
